// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants, FSM state type and rotate helpers for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N    = 8;
  localparam int unsigned IdxW = 3;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  // Result bit i takes v[(i + s) mod N], so the bit at index s lands at bit 0.
  function automatic logic [N-1:0] rot_r(input logic [N-1:0] v, input logic [IdxW-1:0] s);
    logic [2*N-1:0] dbl;
    dbl = {v, v} >> s;
    return dbl[N-1:0];
  endfunction

  // Inverse of rot_r: result bit i takes v[(i - s) mod N].
  function automatic logic [N-1:0] rot_l(input logic [N-1:0] v, input logic [IdxW-1:0] s);
    logic [2*N-1:0] dbl;
    dbl = {v, v} << s;
    return dbl[2*N-1:N];
  endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
  import arb_pkg::*;

  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [IdxW-1:0] grant_idx;
  logic            grant_valid;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid
  );

endinterface

// File: rtl/rr_arbiter_8_prio_enc.sv
// Combinational 8-to-3 priority encoder; the lowest set bit wins.
module prio_enc_8to3 (
  input  logic [7:0] din,
  output logic [2:0] dout,
  output logic       valid
);

  always_comb begin
    dout  = '0;
    valid = |din;
    // Descending scan so the lowest set bit is the last (winning) assignment.
    for (int i = 7; i >= 0; i--) begin
      if (din[i]) dout = 3'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter over 8 requesters with grant hold and optional hold-timeout rotation.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_8_if.slave  bus
);
  import arb_pkg::*;

  localparam int unsigned       HoldW    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0]  MaxHoldC = HoldW'(MAX_HOLD);
  localparam logic [HoldW-1:0]  OneC     = HoldW'(1);

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q;
  logic [HoldW-1:0]  hold_cnt_q;
  logic [N-1:0]      grant_q;
  logic [IdxW-1:0]   idx_q;
  logic              valid_q;

  logic              owner_req;
  logic              others_req;
  logic              preempt;
  logic [IdxW-1:0]   base;
  logic [N-1:0]      cand;
  logic [IdxW-1:0]   enc_off;
  logic              enc_valid;
  logic [IdxW-1:0]   sel_idx;

  // In GRANT the scan starts just past the owner and never considers the owner itself,
  // which covers both release (owner bit already low) and preemption.
  always_comb begin
    owner_req  = |(bus.req & grant_q);
    others_req = |(bus.req & ~grant_q);
    preempt    = owner_req && (MAX_HOLD != 0) && (hold_cnt_q == MaxHoldC) && others_req;
    base       = (state_q == StGrant) ? idx_q + 3'd1 : ptr_q;
    cand       = (state_q == StGrant) ? (bus.req & ~grant_q) : bus.req;
    sel_idx    = base + enc_off;
  end

  prio_enc_8to3 u_enc (
    .din   (rot_r(cand, base)),
    .dout  (enc_off),
    .valid (enc_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (enc_valid) begin
            grant_q    <= N'(1) << sel_idx;
            idx_q      <= sel_idx;
            valid_q    <= 1'b1;
            hold_cnt_q <= OneC;
            state_q    <= StGrant;
          end
        end
        StGrant: begin
          if (!owner_req || preempt) begin
            ptr_q <= idx_q + 3'd1;
            if (enc_valid) begin
              grant_q    <= N'(1) << sel_idx;
              idx_q      <= sel_idx;
              hold_cnt_q <= OneC;
            end else begin
              grant_q    <= '0;
              idx_q      <= '0;
              valid_q    <= 1'b0;
              hold_cnt_q <= '0;
              state_q    <= StIdle;
            end
          end else if ((MAX_HOLD != 0) && (hold_cnt_q < MaxHoldC)) begin
            hold_cnt_q <= hold_cnt_q + OneC;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 (MAX_HOLD=4) with per-cycle output invariant checks.
module tb_rr_arbiter_8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(
    .MAX_HOLD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] encode(input logic [7:0] g);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (g[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Inputs change 2 time units after the rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] g_exp);
    logic [2:0] i_exp;
    logic       v_exp;
    i_exp = encode(g_exp);
    v_exp = |g_exp;
    vectors++;
    assert (bus.grant === g_exp) else begin
      miscompares++;
      $error("FAIL %s grant: got %b want %b", tag, bus.grant, g_exp);
    end
    vectors++;
    assert (bus.grant_idx === i_exp) else begin
      miscompares++;
      $error("FAIL %s grant_idx: got %0d want %0d", tag, bus.grant_idx, i_exp);
    end
    vectors++;
    assert (bus.grant_valid === v_exp) else begin
      miscompares++;
      $error("FAIL %s grant_valid: got %b want %b", tag, bus.grant_valid, v_exp);
    end
  endtask

  always @(negedge clk) begin
    vectors++;
    assert ($onehot0(bus.grant) && (bus.grant_valid === (|bus.grant)) &&
            (bus.grant_idx === encode(bus.grant))) else begin
      miscompares++;
      $error("FAIL invariant: grant=%b idx=%0d valid=%b", bus.grant, bus.grant_idx,
             bus.grant_valid);
    end
  end

  initial begin
    // 1. Reset with every request asserted
    bus.req = 8'hFF;
    rst_n   = 1'b0;
    tick();
    tick();
    chk("reset", 8'h00);
    rst_n   = 1'b1;
    bus.req = 8'h00;
    tick();
    chk("idle_after_reset", 8'h00);

    // 2. Single requester, then release (ptr -> 3)
    bus.req = 8'b0000_0100;
    tick();
    chk("single_grant", 8'b0000_0100);
    bus.req = 8'h00;
    tick();
    chk("single_release", 8'h00);

    // 3. Round-robin from ptr=3: wrap to 0, hand over to 2 without a bubble, back to 0
    bus.req = 8'b0000_0101;
    tick();
    chk("rr_wrap_idx0", 8'b0000_0001);
    bus.req = 8'b0000_0100;
    tick();
    chk("rr_handover_idx2", 8'b0000_0100);
    bus.req = 8'b0000_0001;
    tick();
    chk("rr_back_idx0", 8'b0000_0001);
    bus.req = 8'h00;
    tick();
    chk("rr_idle", 8'h00);

    // 4. Timeout rotation between 0 and 7 (fresh reset so ptr=0)
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    bus.req = 8'b1000_0001;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("hold_idx0_c%0d", k), 8'b0000_0001);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("preempt_idx7_c%0d", k), 8'b1000_0000);
    end
    tick();
    chk("preempt_back_idx0", 8'b0000_0001);
    bus.req = 8'h00;
    tick();
    chk("timeout_idle", 8'h00);

    // 5. Sole requester is never preempted
    bus.req = 8'b0001_0000;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("sole_idx4_c%0d", k), 8'b0001_0000);
    end

    // 6. Reset mid-grant clears outputs and ptr
    bus.req = 8'b0010_0000;
    tick();
    chk("owner_idx5", 8'b0010_0000);
    rst_n   = 1'b0;
    bus.req = 8'b0010_0010;
    tick();
    chk("midgrant_reset", 8'h00);
    rst_n = 1'b1;
    tick();
    chk("post_reset_idx1", 8'b0000_0010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
